// File: rtl/mem_responder_pkg.sv
// Shared types and default geometry for the memory responder.
package mem_responder_pkg;
  localparam int DEF_ADDR_W   = 6;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_OUT_ADDR = 63;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port RAM: synchronous write, registered read with an enable so the
// read register holds its value between reads.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  // Storage is deliberately left out of reset so a preload survives it.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// CPU-facing memory responder: preloads the RAM from a stream, then serves
// CPU reads/writes and mirrors writes at OUT_ADDR onto an output port.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int OUT_ADDR = DEF_OUT_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] adr_bus,
  input  logic              rd_mem,
  input  logic              wr_mem,
  input  logic [DATA_W-1:0] d_out,
  output logic [DATA_W-1:0] d_in,
  output logic              rd_valid,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              cpu_hold,
  output logic [DATA_W-1:0] out_port,
  output logic              out_strobe,
  output logic              err_collision
);
  localparam logic [ADDR_W-1:0] OUT_A = ADDR_W'(OUT_ADDR);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] out_port_q, out_port_d;
  logic              out_strobe_q, out_strobe_d;
  logic              err_q, err_d;

  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    rd_valid_d   = 1'b0;
    out_port_d   = out_port_q;
    out_strobe_d = 1'b0;
    err_d        = err_q;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_addr     = adr_bus;
    mem_wdata    = d_out;
    load_ready   = 1'b0;
    cpu_hold     = 1'b0;

    case (state_q)
      LOAD: begin
        load_ready = 1'b1;
        cpu_hold   = 1'b1;
        mem_addr   = ptr_q;
        mem_wdata  = load_data;
        if (load_valid) begin
          mem_we = 1'b1;
          if (load_last) begin
            ptr_d   = '0;
            state_d = RUN;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      RUN: begin
        // On a collision the write wins and the read is silently dropped.
        if (wr_mem) begin
          mem_we = 1'b1;
          if (adr_bus == OUT_A) begin
            out_port_d   = d_out;
            out_strobe_d = 1'b1;
          end
          if (rd_mem) err_d = 1'b1;
        end else if (rd_mem) begin
          mem_re     = 1'b1;
          rd_valid_d = 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= LOAD;
      ptr_q        <= '0;
      rd_valid_q   <= 1'b0;
      out_port_q   <= '0;
      out_strobe_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rd_valid_q   <= rd_valid_d;
      out_port_q   <= out_port_d;
      out_strobe_q <= out_strobe_d;
      err_q        <= err_d;
    end
  end

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk  (clk),
    .rst_n(reset),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(d_in)
  );

  assign rd_valid      = rd_valid_q;
  assign out_port      = out_port_q;
  assign out_strobe    = out_strobe_q;
  assign err_collision = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mem_responder;
  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 8;
  localparam int OUT_ADDR = 63;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] adr_bus = '0;
  logic              rd_mem = 1'b0;
  logic              wr_mem = 1'b0;
  logic [DATA_W-1:0] d_out = '0;
  logic [DATA_W-1:0] d_in;
  logic              rd_valid;
  logic              load_valid = 1'b0;
  logic [DATA_W-1:0] load_data = '0;
  logic              load_last = 1'b0;
  logic              load_ready;
  logic              cpu_hold;
  logic [DATA_W-1:0] out_port;
  logic              out_strobe;
  logic              err_collision;

  mem_responder #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .OUT_ADDR(OUT_ADDR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .adr_bus      (adr_bus),
    .rd_mem       (rd_mem),
    .wr_mem       (wr_mem),
    .d_out        (d_out),
    .d_in         (d_in),
    .rd_valid     (rd_valid),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .cpu_hold     (cpu_hold),
    .out_port     (out_port),
    .out_strobe   (out_strobe),
    .err_collision(err_collision)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [DATA_W-1:0] ref_mem [2**ADDR_W];
  logic [ADDR_W-1:0] ref_ptr = '0;
  logic              exp_load = 1'b1;
  logic              exp_err = 1'b0;
  logic [DATA_W-1:0] last_din = '0;
  logic [DATA_W-1:0] last_out = '0;
  logic [DATA_W-1:0] exp_rd_q [$];
  logic [DATA_W-1:0] exp_out_q [$];
  logic              mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("rd_valid", {31'b0, rd_valid}, {31'b0, exp_rd_q.size() > 0});
      if (exp_rd_q.size() > 0) last_din = exp_rd_q.pop_front();
      chk("d_in", {24'b0, d_in}, {24'b0, last_din});
      chk("out_strobe", {31'b0, out_strobe}, {31'b0, exp_out_q.size() > 0});
      if (exp_out_q.size() > 0) last_out = exp_out_q.pop_front();
      chk("out_port", {24'b0, out_port}, {24'b0, last_out});
      chk("err_collision", {31'b0, err_collision}, {31'b0, exp_err});
      chk("load_ready", {31'b0, load_ready}, {31'b0, exp_load});
      chk("cpu_hold", {31'b0, cpu_hold}, {31'b0, exp_load});
    end
  end

  // One clock of stimulus; called just after a rising edge.
  task automatic drive(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic lv,
                       input logic [DATA_W-1:0] ld, input logic ll);
    logic              nxt_load = exp_load;
    logic              nxt_err = exp_err;
    logic              has_rd = 1'b0;
    logic              has_out = 1'b0;
    logic [DATA_W-1:0] rd_val = '0;
    rd_mem = rd; wr_mem = wr; adr_bus = a; d_out = d;
    load_valid = lv; load_data = ld; load_last = ll;
    if (exp_load) begin
      if (lv) begin
        ref_mem[ref_ptr] = ld;
        if (ll) begin
          ref_ptr  = '0;
          nxt_load = 1'b0;
        end else begin
          ref_ptr = ref_ptr + 1'b1;
        end
      end
    end else if (wr) begin
      ref_mem[a] = d;
      if (int'(a) == OUT_ADDR) has_out = 1'b1;
      if (rd) nxt_err = 1'b1;
    end else if (rd) begin
      has_rd = 1'b1;
      rd_val = ref_mem[a];
    end
    @(posedge clk);
    exp_load = nxt_load;
    exp_err  = nxt_err;
    if (has_rd) exp_rd_q.push_back(rd_val);
    if (has_out) exp_out_q.push_back(d);
    #1;
  endtask

  task automatic run_op(input logic rd, input logic wr, input int a, input int d);
    drive(rd, wr, ADDR_W'(a), DATA_W'(d), 1'b0, '0, 1'b0);
  endtask

  // CPU strobes are randomised during loads; they must be ignored.
  task automatic load_op(input logic lv, input int ld, input logic ll);
    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ADDR_W'($urandom),
          DATA_W'($urandom), lv, DATA_W'(ld), ll);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_op(1'b0, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_d_in", {24'b0, d_in}, 32'h0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
    chk("rst_load_ready", {31'b0, load_ready}, 32'h1);
    chk("rst_cpu_hold", {31'b0, cpu_hold}, 32'h1);
    chk("rst_out_port", {24'b0, out_port}, 32'h0);
    chk("rst_out_strobe", {31'b0, out_strobe}, 32'h0);
    chk("rst_err", {31'b0, err_collision}, 32'h0);
    exp_load = 1'b1; exp_err = 1'b0; ref_ptr = '0;
    last_din = '0; last_out = '0;
    exp_rd_q.delete(); exp_out_q.delete();
    rd_mem = 1'b0; wr_mem = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    int r;
    int a;
    @(posedge clk);
    #1;
    do_reset();

    // Full-depth preload without last, then a wrapping final word.
    load_op(1'b0, 0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      load_op(1'b1, int'($urandom_range(0, 255)), 1'b0);
      if (i % 17 == 3) load_op(1'b0, 0, 1'b1);
    end
    load_op(1'b1, 'hEE, 1'b1);
    for (int i = 0; i < 64; i++) run_op(1'b1, 1'b0, i, 0);
    idle(2);

    // Short preload then readback.
    do_reset();
    load_op(1'b1, 'h11, 1'b0);
    load_op(1'b1, 'h22, 1'b0);
    load_op(1'b1, 'h33, 1'b1);
    for (int i = 0; i < 3; i++) run_op(1'b1, 1'b0, i, 0);
    idle(2);

    run_op(1'b0, 1'b1, 5, 'hA5);
    run_op(1'b1, 1'b0, 5, 0);
    idle(2);

    run_op(1'b0, 1'b1, 63, 'h7E);
    idle(2);
    run_op(1'b1, 1'b0, 63, 0);
    idle(2);

    run_op(1'b1, 1'b1, 9, 'h3C);
    idle(2);
    run_op(1'b1, 1'b0, 9, 0);
    idle(2);

    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      a = ($urandom_range(0, 7) == 0) ? OUT_ADDR : int'($urandom_range(0, 63));
      if (r < 4)       run_op(1'b1, 1'b0, a, 0);
      else if (r < 7)  run_op(1'b0, 1'b1, a, int'($urandom_range(0, 255)));
      else if (r == 7) run_op(1'b1, 1'b1, a, int'($urandom_range(0, 255)));
      else             idle(1);
    end
    idle(2);

    // Reset part-way through a preload.
    do_reset();
    load_op(1'b1, 'hA1, 1'b0);
    load_op(1'b1, 'hA2, 1'b0);
    do_reset();
    load_op(1'b1, 'hB0, 1'b0);
    load_op(1'b1, 'hB1, 1'b0);
    load_op(1'b1, 'hB2, 1'b0);
    load_op(1'b1, 'hB3, 1'b1);
    for (int i = 0; i < 4; i++) run_op(1'b1, 1'b0, i, 0);
    run_op(1'b1, 1'b0, 20, 0);
    run_op(1'b1, 1'b0, 63, 0);
    idle(3);

    chk("rd_queue_drained", exp_rd_q.size(), 32'h0);
    chk("out_queue_drained", exp_out_q.size(), 32'h0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 6, CPU address width; memory depth is 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 8, data word width.
REQ-003 Parameter OUT_ADDR, default 63, address mirrored to the output port.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 adr_bus  input  ADDR_W  CPU address.
REQ-007 rd_mem  input  1  CPU read strobe.
REQ-008 wr_mem  input  1  CPU write strobe.
REQ-009 d_out  input  DATA_W  CPU write data.
REQ-010 d_in  output  DATA_W  read data returned to the CPU.
REQ-011 rd_valid  output  1  one-cycle pulse marking d_in updated by a read.
REQ-012 load_valid / load_data / load_last  input  1 / DATA_W / 1  preload stream: valid, word, final-word marker.
REQ-013 load_ready  output  1  preload word accepted when high with load_valid.
REQ-014 cpu_hold  output  1  high while preloading; CPU must not access memory.
REQ-015 out_port  output  DATA_W  last value written to OUT_ADDR.
REQ-016 out_strobe  output  1  one-cycle pulse on each write to OUT_ADDR.
REQ-017 err_collision  output  1  sticky flag: rd_mem and wr_mem sampled high together.

Function
REQ-018 FSM has two states, LOAD and RUN; reset enters LOAD.
REQ-019 In LOAD, load_ready=1 and cpu_hold=1; rd_mem/wr_mem are ignored.
REQ-020 LOAD: each edge with load_valid=1 writes load_data to mem[ptr] and increments ptr; ptr wraps from 2**ADDR_W-1 to 0.
REQ-021 LOAD: an accepted word with load_last=1 is written, then the FSM moves to RUN on the same edge; ptr returns to 0.
REQ-022 In RUN, load_ready=0, cpu_hold=0, and the load inputs are ignored; RUN exits only via reset.
REQ-023 RUN read: rd_mem=1 at edge N loads d_in=mem[adr_bus] and drives rd_valid=1 during cycle N+1 (1-cycle latency); back-to-back reads are served every cycle.
REQ-024 d_in holds its last value when no read occurs; rd_valid=0 otherwise.
REQ-025 RUN write: wr_mem=1 at edge N writes d_out into mem[adr_bus]; a read of the same address at edge N+1 returns the new data.
REQ-026 A write to OUT_ADDR also loads out_port=d_out and pulses out_strobe during cycle N+1.
REQ-027 Collision (rd_mem=1 and wr_mem=1 at one RUN edge): the write is performed, the read is dropped (d_in holds, rd_valid=0), and err_collision is set until reset.
REQ-028 Out-of-range addresses cannot occur; full ADDR_W decode with no aliasing.

Reset
REQ-029 reset low: state=LOAD, ptr=0, d_in=0, rd_valid=0, out_port=0, out_strobe=0, err_collision=0, load_ready=1, cpu_hold=1, asynchronously.
REQ-030 Memory array contents are not cleared by reset; reset during LOAD discards the partial load position only (ptr=0), not the data already written.

Structure
REQ-031 Shared package holds the state enum (LOAD, RUN) and the default ADDR_W, DATA_W, and OUT_ADDR constants.
REQ-032 Storage is one sub-module, mem_array: a single-port synchronous-write, registered-read DATA_W x 2**ADDR_W RAM; mem_responder multiplexes the load and CPU ports onto it.

Verification
REQ-033 Preload 0x11,0x22,0x33 (last on 0x33) -> load_ready falls, cpu_hold falls, FSM in RUN; reads of addresses 0,1,2 return 0x11,0x22,0x33 each with rd_valid one cycle after the strobe.
REQ-034 RUN: write 0xA5 to addr 5, read addr 5 on the next edge -> d_in=0xA5 with rd_valid pulsed once.
REQ-035 Write 0x7E to addr 63 -> out_port=0x7E and out_strobe high for exactly one cycle; mem[63] reads back 0x7E.
REQ-036 rd_mem=wr_mem=1, addr 9, d_out=0x3C -> err_collision=1 and stays high, d_in unchanged, rd_valid=0; a later read of addr 9 returns 0x3C.
REQ-037 Preload 64 words without load_last, then 1 more word 0xEE with load_last -> mem[0]=0xEE (ptr wrap).
REQ-038 Assert reset after 2 of 4 preload words -> outputs at reset values immediately; FSM in LOAD with ptr=0; the next word lands at addr 0.
